rout_monitor: RTL and testbench

- Downstream consumer of the system's general-register output bus (Rout).
- Watches the 32-bit Rout value every cycle and detects each change.
- Buffers each new value in a small FIFO, then hands it to a debug or display sink over a valid/ready handshake.
- Counts values lost to FIFO overflow, so a program trace can be checked after a run without stalling the datapath.

---
 rtl/rout_monitor_if.sv | 44 ++++
 rtl/rout_monitor.sv | 102 ++++++++++
 tb/tb_rout_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rout_monitor_if.sv
// Rout monitor bundle: sampled bus, control and sink handshake.
// The monitor is the slave; the system/sink side is the master.
interface rout_monitor_if #(
    parameter int DATAWIDTH_BUS            = 32,
    parameter int FIFO_DEPTH_LOG2          = 3,
    parameter int DATAWIDTH_OVERFLOW_COUNT = 8
);
    logic [DATAWIDTH_BUS-1:0]            ROUT_MONITOR_Data_InBus;
    logic                                ROUT_MONITOR_Enable_In;
    logic                                ROUT_MONITOR_Clear_In;
    logic                                ROUT_MONITOR_Ready_In;
    logic [DATAWIDTH_BUS-1:0]            ROUT_MONITOR_Data_OutBus;
    logic                                ROUT_MONITOR_Valid_Out;
    logic [FIFO_DEPTH_LOG2:0]            ROUT_MONITOR_Count_OutBus;
    logic                                ROUT_MONITOR_Full_Out;
    logic                                ROUT_MONITOR_Overflow_Out;
    logic [DATAWIDTH_OVERFLOW_COUNT-1:0] ROUT_MONITOR_OverflowCount_OutBus;

    modport master (
        output ROUT_MONITOR_Data_InBus,
        output ROUT_MONITOR_Enable_In,
        output ROUT_MONITOR_Clear_In,
        output ROUT_MONITOR_Ready_In,
        input  ROUT_MONITOR_Data_OutBus,
        input  ROUT_MONITOR_Valid_Out,
        input  ROUT_MONITOR_Count_OutBus,
        input  ROUT_MONITOR_Full_Out,
        input  ROUT_MONITOR_Overflow_Out,
        input  ROUT_MONITOR_OverflowCount_OutBus
    );

    modport slave (
        input  ROUT_MONITOR_Data_InBus,
        input  ROUT_MONITOR_Enable_In,
        input  ROUT_MONITOR_Clear_In,
        input  ROUT_MONITOR_Ready_In,
        output ROUT_MONITOR_Data_OutBus,
        output ROUT_MONITOR_Valid_Out,
        output ROUT_MONITOR_Count_OutBus,
        output ROUT_MONITOR_Full_Out,
        output ROUT_MONITOR_Overflow_Out,
        output ROUT_MONITOR_OverflowCount_OutBus
    );
endinterface

// File: rtl/rout_monitor.sv
// Rout change monitor: captures each new bus value into a FIFO
// drained over valid/ready, counting values lost to overflow.
module rout_monitor #(
    parameter int DATAWIDTH_BUS            = 32,
    parameter int FIFO_DEPTH_LOG2          = 3,
    parameter int DATAWIDTH_OVERFLOW_COUNT = 8
) (
    input logic         ROUT_MONITOR_CLOCK_50,
    input logic         ROUT_MONITOR_ResetInLow_In,
    rout_monitor_if.slave mon
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = DEPTH[FIFO_DEPTH_LOG2:0];

    logic [DATAWIDTH_BUS-1:0]            mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]          wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]          rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]            count;
    logic [DATAWIDTH_BUS-1:0]            prev;
    logic                                primed;
    logic                                ovf;
    logic [DATAWIDTH_OVERFLOW_COUNT-1:0] ovf_cnt;

    logic full;
    logic valid;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    // Handshake and capture decisions for this edge.
    always_comb begin
        full    = (count == DEPTH_C);
        valid   = (count != '0);
        capture = mon.ROUT_MONITOR_Enable_In &&
                  (!primed || (mon.ROUT_MONITOR_Data_InBus != prev));
        pop     = valid && mon.ROUT_MONITOR_Ready_In;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    // Change detector: last sample and primed flag.
    always_ff @(posedge ROUT_MONITOR_CLOCK_50 or negedge ROUT_MONITOR_ResetInLow_In) begin
        if (!ROUT_MONITOR_ResetInLow_In) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (mon.ROUT_MONITOR_Clear_In) begin
            primed <= 1'b0;
        end else if (mon.ROUT_MONITOR_Enable_In) begin
            prev   <= mon.ROUT_MONITOR_Data_InBus;
            primed <= 1'b1;
        end
    end

    // FIFO storage; reset zeroes it so the head reads 0 after reset.
    always_ff @(posedge ROUT_MONITOR_CLOCK_50 or negedge ROUT_MONITOR_ResetInLow_In) begin
        if (!ROUT_MONITOR_ResetInLow_In) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!mon.ROUT_MONITOR_Clear_In && push) begin
            mem[wr_ptr] <= mon.ROUT_MONITOR_Data_InBus;
        end
    end

    // Pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge ROUT_MONITOR_CLOCK_50 or negedge ROUT_MONITOR_ResetInLow_In) begin
        if (!ROUT_MONITOR_ResetInLow_In) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mon.ROUT_MONITOR_Clear_In) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge ROUT_MONITOR_CLOCK_50 or negedge ROUT_MONITOR_ResetInLow_In) begin
        if (!ROUT_MONITOR_ResetInLow_In) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (mon.ROUT_MONITOR_Clear_In) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign mon.ROUT_MONITOR_Data_OutBus          = mem[rd_ptr];
    assign mon.ROUT_MONITOR_Valid_Out            = valid;
    assign mon.ROUT_MONITOR_Count_OutBus         = count;
    assign mon.ROUT_MONITOR_Full_Out             = full;
    assign mon.ROUT_MONITOR_Overflow_Out         = ovf;
    assign mon.ROUT_MONITOR_OverflowCount_OutBus = ovf_cnt;
endmodule

// File: tb/tb_rout_monitor.sv
// Directed bench for rout_monitor: vector table plus
// hand-written overflow, saturation, clear and reset sequences.
module tb_rout_monitor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rout_monitor_if #(.DATAWIDTH_BUS(32), .FIFO_DEPTH_LOG2(3),
                      .DATAWIDTH_OVERFLOW_COUNT(8)) bus ();

    rout_monitor #(.DATAWIDTH_BUS(32), .FIFO_DEPTH_LOG2(3),
                   .DATAWIDTH_OVERFLOW_COUNT(8)) dut (
        .ROUT_MONITOR_CLOCK_50      (clk),
        .ROUT_MONITOR_ResetInLow_In (rst_n),
        .mon                        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] din;
        logic        clr;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_count;
        logic        chk_dout;
        logic [31:0] e_dout;
        logic        e_full;
        logic        e_ovf;
        logic [7:0]  e_ocnt;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] din,
                         input logic clr, input logic rdy);
        bus.ROUT_MONITOR_Enable_In  = en;
        bus.ROUT_MONITOR_Data_InBus = din;
        bus.ROUT_MONITOR_Clear_In   = clr;
        bus.ROUT_MONITOR_Ready_In   = rdy;
    endtask

    task automatic step(input logic en, input logic [31:0] din,
                        input logic clr, input logic rdy);
        drive(en, din, clr, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v,
                           input logic [3:0] c, input logic [31:0] d,
                           input logic cd, input logic f,
                           input logic o, input logic [7:0] oc);
        chk({tag, ".valid"}, 32'(bus.ROUT_MONITOR_Valid_Out), 32'(v));
        chk({tag, ".count"}, 32'(bus.ROUT_MONITOR_Count_OutBus), 32'(c));
        if (cd) chk({tag, ".dout"}, bus.ROUT_MONITOR_Data_OutBus, d);
        chk({tag, ".full"}, 32'(bus.ROUT_MONITOR_Full_Out), 32'(f));
        chk({tag, ".ovf"}, 32'(bus.ROUT_MONITOR_Overflow_Out), 32'(o));
        chk({tag, ".ocnt"},
            32'(bus.ROUT_MONITOR_OverflowCount_OutBus), 32'(oc));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Change-detect with a sink that is always ready.
        vecs.push_back('{1, 32'h11, 0, 1, 1, 4'd1, 1, 32'h11, 0, 0, 8'd0});
        vecs.push_back('{1, 32'h11, 0, 1, 0, 4'd0, 0, 32'h0,  0, 0, 8'd0});
        vecs.push_back('{1, 32'h22, 0, 1, 1, 4'd1, 1, 32'h22, 0, 0, 8'd0});
        vecs.push_back('{1, 32'h33, 0, 1, 1, 4'd1, 1, 32'h33, 0, 0, 8'd0});
        vecs.push_back('{1, 32'h33, 0, 1, 0, 4'd0, 0, 32'h0,  0, 0, 8'd0});
        // Empty with ready: nothing moves.
        vecs.push_back('{0, 32'h44, 0, 1, 0, 4'd0, 0, 32'h0,  0, 0, 8'd0});
        // Fill to overflow with ready low.
        for (int i = 1; i <= 10; i++) begin
            vecs.push_back('{1, 32'(i), 0, 0, 1,
                             (i > 8) ? 4'd8 : 4'(i), 1, 32'h1,
                             (i >= 8), (i > 8),
                             (i > 8) ? 8'(i - 8) : 8'd0});
        end

        #12;
        chk_all("reset", 0, 0, 32'h0, 1, 0, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant zero bus: only the first sample is stored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0, 1'b0, 1'b0);
            chk_all($sformatf("zero%0d", i), 1, 1, 32'h0, 1, 0, 0, 8'd0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_all("clr0", 0, 0, 32'h0, 0, 0, 0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].din, vecs[i].clr, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid,
                    vecs[i].e_count, vecs[i].e_dout, vecs[i].chk_dout,
                    vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_ocnt);
        end

        // Drain yields 1..8 in order.
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d", i), bus.ROUT_MONITOR_Data_OutBus,
                32'(i));
            step(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk_all("drained", 0, 0, 32'h0, 0, 0, 1, 8'd2);

        // Refill with 11..18, then push-while-pop at full.
        for (int i = 11; i <= 18; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk_all("refill", 1, 8, 32'd11, 1, 1, 1, 8'd2);
        step(1'b1, 32'd19, 1'b0, 1'b1);
        chk_all("fullpp", 1, 8, 32'd12, 1, 1, 1, 8'd2);

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
        chk_all("sat", 1, 8, 32'd12, 1, 1, 1, 8'hFF);

        // Pop three to leave five entries, then clear.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_all("five", 1, 5, 32'd15, 1, 0, 1, 8'hFF);
        step(1'b1, 32'hABC, 1'b1, 1'b1);
        chk_all("clear", 0, 0, 32'h0, 0, 0, 0, 8'd0);
        step(1'b1, 32'd399, 1'b0, 1'b0);
        chk_all("reprime", 1, 1, 32'd399, 1, 0, 0, 8'd0);

        // Async reset mid-run with three entries held.
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h201, 1'b0, 1'b0);
        chk_all("three", 1, 3, 32'd399, 1, 0, 0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async", 0, 0, 32'h0, 1, 0, 0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_all("postrst", 0, 0, 32'h0, 1, 0, 0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
